// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte sources, one whole packet at a time.
// Optional idle-lock release: define UART_TX_ARB_TIMEOUT_EN to enable the LOCK_TIMEOUT counter.
module uart_tx_arb #(
   parameter int N_REQ        = 4,
   parameter int LOCK_TIMEOUT = 1_000_000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_REQ-1:0]   req_valid,
   input  logic [8*N_REQ-1:0] req_data,
   input  logic [N_REQ-1:0]   req_last,
   output logic [N_REQ-1:0]   req_ack,
   output logic [7:0]         data_tx,
   output logic               ready_tx,
   input  logic               done_tx,
   output logic [N_REQ-1:0]   grant,
   output logic               busy,
   output logic [1:0]         dbg_state
);
   localparam int IW = $clog2(N_REQ);

   if (N_REQ < 2 || N_REQ > 8 || LOCK_TIMEOUT < 2) begin : g_bad_param
      $error("uart_tx_arb: N_REQ must be 2..8 and LOCK_TIMEOUT at least 2");
   end

   // Handshake: a byte is captured in IDLE/LOCK and acknowledged with a one-cycle req_ack;
   // ready_tx then offers it until done_tx is seen while ready_tx=1.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2,
      LOCK = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [IW-1:0]      owner_q, owner_d;
   logic [IW-1:0]      last_owner_q, last_owner_d;
   logic [7:0]         data_q, data_d;
   logic               last_q, last_d;
   logic               ready_q, ready_d;
   logic [N_REQ-1:0]   ack_q, ack_d;
   logic [N_REQ-1:0]   grant_q, grant_d;
   logic               rr_hit;
   logic [IW-1:0]      rr_idx;
   int                 rr_j;
   logic               cap_en;
   logic [IW-1:0]      cap_idx;

`ifdef UART_TX_ARB_TIMEOUT_EN
   localparam int CW = $clog2(LOCK_TIMEOUT);
   logic [CW-1:0]      lock_cnt_q, lock_cnt_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lock_cnt_q <= '0;
      end else begin
         lock_cnt_q <= lock_cnt_d;
      end
   end
`endif

   // Scan downwards so the candidate nearest to last_owner+1 wins.
   always_comb begin
      rr_hit = 1'b0;
      rr_idx = '0;
      rr_j   = 0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         rr_j = (int'(last_owner_q) + 1 + k) % N_REQ;
         if (req_valid[rr_j]) begin
            rr_hit = 1'b1;
            rr_idx = IW'(rr_j);
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      data_d       = data_q;
      last_d       = last_q;
      ack_d        = '0;
      grant_d      = grant_q;
      cap_en       = 1'b0;
      cap_idx      = owner_q;
`ifdef UART_TX_ARB_TIMEOUT_EN
      lock_cnt_d   = '0;
`endif
      case (state_q)
         IDLE: begin
            if (rr_hit) begin
               cap_en  = 1'b1;
               cap_idx = rr_idx;
               owner_d = rr_idx;
               grant_d = N_REQ'(1) << rr_idx;
               state_d = SEND;
            end
         end
         SEND: begin
            if (done_tx && ready_q) begin
               state_d = GAP;
            end
         end
         GAP: begin
            if (last_q) begin
               grant_d      = '0;
               last_owner_d = owner_q;
               state_d      = IDLE;
            end else begin
               state_d = LOCK;
            end
         end
         LOCK: begin
            if (req_valid[owner_q]) begin
               cap_en  = 1'b1;
               state_d = SEND;
`ifdef UART_TX_ARB_TIMEOUT_EN
            end else if (lock_cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
               grant_d      = '0;
               last_owner_d = owner_q;
               state_d      = IDLE;
            end else begin
               lock_cnt_d = lock_cnt_q + 1'b1;
`endif
            end
         end
         default: state_d = IDLE;
      endcase

      if (cap_en) begin
         data_d         = req_data[cap_idx*8 +: 8];
         last_d         = req_last[cap_idx];
         ack_d[cap_idx] = 1'b1;
      end
      // The first SEND cycle carries the ack; the byte is offered from the second.
      ready_d = (state_q == SEND) && (state_d == SEND);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         owner_q      <= '0;
         last_owner_q <= IW'(N_REQ - 1);
         data_q       <= '0;
         last_q       <= 1'b0;
         ready_q      <= 1'b0;
         ack_q        <= '0;
         grant_q      <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         data_q       <= data_d;
         last_q       <= last_d;
         ready_q      <= ready_d;
         ack_q        <= ack_d;
         grant_q      <= grant_d;
      end
   end

   assign req_ack   = ack_q;
   assign data_tx   = data_q;
   assign ready_tx  = ready_q;
   assign grant     = grant_q;
   assign busy      = (state_q != IDLE);
   assign dbg_state = state_q;
endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: queued requester drivers, a transmitter model that returns done_tx,
// and a scoreboard of expected {grant, byte} pairs in transmit order.
module tb_uart_tx_arb;
   localparam int N = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [N-1:0]  req_valid = '0;
   logic [8*N-1:0] req_data = '0;
   logic [N-1:0]  req_last = '0;
   logic [N-1:0]  req_ack;
   logic [7:0]    data_tx;
   logic          ready_tx;
   logic          done_tx = 1'b0;
   logic [N-1:0]  grant;
   logic          busy;
   logic [1:0]    dbg_state;

   uart_tx_arb #(.N_REQ(N), .LOCK_TIMEOUT(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_last  (req_last),
      .req_ack   (req_ack),
      .data_tx   (data_tx),
      .ready_tx  (ready_tx),
      .done_tx   (done_tx),
      .grant     (grant),
      .busy      (busy),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   int          errors = 0;
   int          checks = 0;
   logic [11:0] exp_q[$];
   logic [8:0]  rq[N][$];
   int          ack_cnt[N];
   int          fixed_delay = 0;
   bit          spur_done = 1'b0;
   int          cur_delay = 1;
   int          rcnt = 0;
   logic [7:0]  held_data = '0;
   bit          gap_chk = 1'b0;
   bit          prev_busy = 1'b0;
   logic [N-1:0] prev_grant = '0;
   logic [8:0]  head;
   logic [11:0] exp_v;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic bit rq_empty();
      for (int i = 0; i < N; i++) if (rq[i].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   // Requesters, transmitter model and scoreboard all act on the falling edge.
   always @(negedge clk) begin
      check("ack_onehot0", 32'($onehot0(req_ack)), 1);
      for (int i = 0; i < N; i++) begin
         if (req_ack[i]) begin
            ack_cnt[i]++;
            if (rq[i].size() > 0) void'(rq[i].pop_front());
         end
         if (rq[i].size() > 0) begin
            head = rq[i][0];
            req_valid[i] = 1'b1;
            req_data[8*i +: 8] = head[7:0];
            req_last[i] = head[8];
         end else begin
            req_valid[i] = 1'b0;
            req_data[8*i +: 8] = 8'h00;
            req_last[i] = 1'b0;
         end
      end
      if (!rst_n) begin
         done_tx = 1'b0;
         rcnt    = 0;
         gap_chk = 1'b0;
      end else begin
         if (gap_chk) begin
            check("gap_ready_low", 32'(ready_tx), 0);
            gap_chk = 1'b0;
         end
         if (ready_tx) begin
            if (rcnt == 0) begin
               cur_delay = (fixed_delay > 0) ? fixed_delay : int'($urandom_range(1, 4));
               held_data = data_tx;
            end else begin
               check("data_stable", 32'(data_tx), 32'(held_data));
            end
            rcnt++;
            if (rcnt >= cur_delay) begin
               done_tx = 1'b1;
               rcnt    = 0;
               gap_chk = 1'b1;
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL sb_unexpected: got grant=%0h byte=%0h, required nothing", grant, data_tx);
               end else begin
                  exp_v = exp_q.pop_front();
                  check("sb_byte", 32'({grant, data_tx}), 32'(exp_v));
               end
            end else begin
               done_tx = 1'b0;
            end
         end else begin
            rcnt      = 0;
            done_tx   = spur_done;
            spur_done = 1'b0;
         end
         if (busy) check("grant_onehot", 32'($onehot(grant)), 1);
         if (busy && prev_busy) check("grant_stable", 32'(grant), 32'(prev_grant));
      end
      prev_busy  = busy;
      prev_grant = grant;
   end

   task automatic reset_dut();
      @(posedge clk); #2;
      rst_n = 1'b0;
      exp_q.delete();
      for (int i = 0; i < N; i++) rq[i].delete();
      @(posedge clk); #2;
      rst_n = 1'b1;
   endtask

   task automatic send(input int req, input logic [7:0] data, input bit last);
      rq[req].push_back({last, data});
      exp_q.push_back({4'(1 << req), data});
   endtask

   task automatic wait_idle(input string name, input int budget);
      bit ok = 1'b0;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !busy && rq_empty()) begin
            ok = 1'b1;
            break;
         end
      end
      check(name, 32'(ok), 1);
   endtask

   task automatic wait_state(input string name, input logic [1:0] s, input int budget);
      bit ok = 1'b0;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if (dbg_state == s) begin
            ok = 1'b1;
            break;
         end
      end
      check(name, 32'(ok), 1);
   endtask

   typedef struct {
      int         req;
      logic [7:0] data;
      int         delay;
   } vec_t;

   vec_t tbl[5];
   int   pre[N];
   int   lat;
   int   cnt;

   initial begin
      tbl[0] = '{0, 8'hA5, 10};
      tbl[1] = '{1, 8'h3C, 1};
      tbl[2] = '{2, 8'hFF, 3};
      tbl[3] = '{3, 8'h00, 2};
      tbl[4] = '{0, 8'h5A, 1};

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_ready", 32'(ready_tx), 0);
      check("rst_ack", 32'(req_ack), 0);
      check("rst_grant", 32'(grant), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_data", 32'(data_tx), 0);
      check("rst_state", 32'(dbg_state), 0);
      @(posedge clk); #2;
      rst_n = 1'b1;

      // Isolated single-byte packets: latency, ack count, release.
      foreach (tbl[v]) begin
         fixed_delay = tbl[v].delay;
         pre = ack_cnt;
         @(posedge clk); #2;
         send(tbl[v].req, tbl[v].data, 1'b1);
         @(negedge clk);
         lat = 0;
         for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (ready_tx) begin
               lat = k;
               break;
            end
         end
         check("latency", 32'(lat), 2);
         wait_idle("tbl_idle", 100);
         check("tbl_ack_count", 32'(ack_cnt[tbl[v].req] - pre[tbl[v].req]), 1);
         check("tbl_grant_released", 32'(grant), 0);
      end
      fixed_delay = 0;

      // Every requester busy with single-byte packets: strict rotation from 0.
      reset_dut();
      @(posedge clk); #2;
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < N; i++) send(i, 8'($urandom_range(0, 255)), 1'b1);
      wait_idle("rr_idle", 300);

      // A three-byte packet keeps the grant against a waiting requester.
      reset_dut();
      @(posedge clk); #2;
      send(1, 8'h11, 1'b1);
      wait_idle("pkt_pre_idle", 100);
      pre = ack_cnt;
      @(posedge clk); #2;
      send(2, 8'h2A, 1'b0);
      send(2, 8'h2B, 1'b0);
      send(2, 8'h2C, 1'b1);
      send(1, 8'h12, 1'b1);
      wait_idle("pkt_idle", 300);
      check("pkt_ack_r2", 32'(ack_cnt[2] - pre[2]), 3);
      check("pkt_ack_r1", 32'(ack_cnt[1] - pre[1]), 1);

      // Spurious done_tx while locked and while idle.
      @(posedge clk); #2;
      send(1, 8'h31, 1'b0);
      wait_state("lock_reach", 2'd3, 100);
      pre = ack_cnt;
      spur_done = 1'b1;
      repeat (3) @(negedge clk);
      check("lock_spur_state", 32'(dbg_state), 3);
      check("lock_spur_grant", 32'(grant), 32'h2);
      check("lock_spur_ack", 32'(ack_cnt[1] - pre[1]), 0);
      @(posedge clk); #2;
      send(1, 8'h32, 1'b1);
      wait_idle("lock_finish_idle", 100);
      pre = ack_cnt;
      spur_done = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_spur_busy", 32'(busy), 0);
      check("idle_spur_ack", 32'(ack_cnt[0] + ack_cnt[1] + ack_cnt[2] + ack_cnt[3]
                                 - pre[0] - pre[1] - pre[2] - pre[3]), 0);

      // Reset while locked abandons the packet silently.
      @(posedge clk); #2;
      send(2, 8'h41, 1'b0);
      wait_state("lock2_reach", 2'd3, 100);
      pre = ack_cnt;
      reset_dut();
      @(negedge clk);
      check("lockrst_grant", 32'(grant), 0);
      check("lockrst_busy", 32'(busy), 0);
      check("lockrst_ack", 32'(ack_cnt[2] - pre[2]), 0);

      // Reset mid-SEND, then requester 3 alone is served.
      fixed_delay = 8;
      @(posedge clk); #2;
      rq[0].push_back({1'b1, 8'h77});
      wait_state("send_reach", 2'd1, 100);
      @(negedge clk);
      check("send_ready_before_rst", 32'(ready_tx), 1);
      reset_dut();
      @(negedge clk);
      check("sendrst_ready", 32'(ready_tx), 0);
      check("sendrst_grant", 32'(grant), 0);
      check("sendrst_busy", 32'(busy), 0);
      check("sendrst_data", 32'(data_tx), 0);
      fixed_delay = 0;
      @(posedge clk); #2;
      send(3, 8'h93, 1'b1);
      wait_idle("after_rst_idle", 100);

`ifdef UART_TX_ARB_TIMEOUT_EN
      // Owner stalls after a non-final byte; lock is released after 16 cycles.
      reset_dut();
      @(posedge clk); #2;
      send(0, 8'hB0, 1'b0);
      send(1, 8'hB1, 1'b1);
      wait_state("to_lock_reach", 2'd3, 100);
      cnt = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (grant == '0) begin
            cnt = k;
            break;
         end
      end
      check("timeout_release", 32'(cnt), 16);
      wait_idle("timeout_idle", 100);
`endif

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
      $fatal(1, "watchdog");
   end
endmodule
